calc_key_controller: RTL and testbench

//  Central sequencer of the calculator. Consumes 5-bit key codes from the keypad scanner over valid/ready.

---
 rtl/calc_key_controller.sv | 165 ++++++++++++++++
 tb/tb_calc_key_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_controller.sv
// Calculator sequencer: assembles hex operands from key codes, issues ALU requests
// and chains operators left to right; outputs are registered from next-state values.
module calc_key_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_key,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_error,
  input  logic             i_alu_result_valid,
  output logic [WIDTH-1:0] o_display,
  output logic             o_display_error,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_ALU_REQ, S_ALU_WAIT, S_RESULT, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [1:0]       op_q, op_d, next_op_q, next_op_d;
  logic             chain_q, chain_d;
  logic             key_rdy_q, key_rdy_d, alu_vld_q, alu_vld_d;
  logic             busy_q, busy_d, err_q, err_d;

  logic             key_fire, is_digit, is_op, is_eq, is_ac, resp;
  logic [2:0]       op_m1;
  logic [WIDTH-1:0] digit_z;

  assign key_fire = i_key_valid && key_rdy_q;
  assign is_digit = ~i_key[4];
  assign is_ac    = (i_key == 5'b10000);
  assign is_eq    = (i_key == 5'b10101);
  assign is_op    = (i_key[4:3] == 2'b10) && (i_key[2:0] >= 3'd1) && (i_key[2:0] <= 3'd4);
  assign op_m1    = i_key[2:0] - 3'd1;
  assign digit_z  = {{(WIDTH-4){1'b0}}, i_key[3:0]};
  // A response accepted together with the request is handled as if already waiting.
  assign resp     = i_alu_result_valid &&
                    (state_q == S_ALU_WAIT || (state_q == S_ALU_REQ && i_alu_ready));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;
    if (key_fire) begin
      if (is_ac) begin
        state_d   = S_ENTER_A;
        a_d       = '0;
        b_d       = '0;
        op_d      = '0;
        next_op_d = '0;
        chain_d   = 1'b0;
      end else begin
        case (state_q)
          S_ENTER_A: begin
            if (is_digit && a_q[WIDTH-1:WIDTH-4] == 4'd0) a_d = {a_q[WIDTH-5:0], i_key[3:0]};
            else if (is_op) begin
              op_d    = op_m1[1:0];
              state_d = S_OP_WAIT;
            end
          end
          S_OP_WAIT: begin
            if (is_digit) begin
              b_d     = digit_z;
              state_d = S_ENTER_B;
            end else if (is_op) op_d = op_m1[1:0];
          end
          S_ENTER_B: begin
            if (is_digit && b_q[WIDTH-1:WIDTH-4] == 4'd0) b_d = {b_q[WIDTH-5:0], i_key[3:0]};
            else if (is_op) begin
              next_op_d = op_m1[1:0];
              chain_d   = 1'b1;
              state_d   = S_ALU_REQ;
            end else if (is_eq) begin
              chain_d = 1'b0;
              state_d = S_ALU_REQ;
            end
          end
          S_RESULT: begin
            if (is_digit) begin
              a_d     = digit_z;
              state_d = S_ENTER_A;
            end else if (is_op) begin
              op_d    = op_m1[1:0];
              state_d = S_OP_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
    if (state_q == S_ALU_REQ && i_alu_ready) state_d = S_ALU_WAIT;
    if (resp) begin
      if (i_alu_error) state_d = S_ERROR;
      else begin
        a_d = i_alu_result;
        b_d = '0;
        if (chain_q) begin
          op_d    = next_op_q;
          state_d = S_OP_WAIT;
        end else state_d = S_RESULT;
      end
    end
  end

  always_comb begin
    key_rdy_d = (state_d != S_ALU_REQ) && (state_d != S_ALU_WAIT);
    busy_d    = ~key_rdy_d;
    alu_vld_d = (state_d == S_ALU_REQ);
    err_d     = (state_d == S_ERROR);
    disp_d    = a_d;
    if (state_d == S_ENTER_B) disp_d = b_d;
    else if (state_d == S_ERROR) disp_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      next_op_q <= '0;
      chain_q   <= 1'b0;
      key_rdy_q <= 1'b1;
      busy_q    <= 1'b0;
      alu_vld_q <= 1'b0;
      err_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      next_op_q <= next_op_d;
      chain_q   <= chain_d;
      key_rdy_q <= key_rdy_d;
      busy_q    <= busy_d;
      alu_vld_q <= alu_vld_d;
      err_q     <= err_d;
      disp_q    <= disp_d;
    end
  end

  assign o_key_ready     = key_rdy_q;
  assign o_alu_a         = a_q;
  assign o_alu_b         = b_q;
  assign o_alu_op        = op_q;
  assign o_alu_valid     = alu_vld_q;
  assign o_busy          = busy_q;
  assign o_display       = disp_q;
  assign o_display_error = err_q;

endmodule

// File: tb/tb_calc_key_controller.sv
// Bench for calc_key_controller: directed calculator sessions then random key streams,
// checked against an arithmetic model of the calculator with a bench-side ALU.
module tb_calc_key_controller;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   i_key = '0;
  logic         i_key_valid = 1'b0;
  logic         o_key_ready;
  logic [W-1:0] o_alu_a, o_alu_b;
  logic [1:0]   o_alu_op;
  logic         o_alu_valid;
  logic         i_alu_ready = 1'b0;
  logic [W-1:0] i_alu_result = '0;
  logic         i_alu_error = 1'b0;
  logic         i_alu_result_valid = 1'b0;
  logic [W-1:0] o_display;
  logic         o_display_error;
  logic         o_busy;

  calc_key_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_key(i_key), .i_key_valid(i_key_valid),
    .o_key_ready(o_key_ready), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
    .i_alu_result_valid(i_alu_result_valid), .o_display(o_display),
    .o_display_error(o_display_error), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Calculator model: mode 0 typing A, 1 operator given, 2 typing B, 3 ALU busy, 4 result, 5 error
  int m_a, m_b, m_op, m_next, m_mode;
  bit m_chain;
  bit force_en;
  int force_res;
  bit force_err;

  task automatic m_reset();
    m_a = 0; m_b = 0; m_op = 0; m_next = 0; m_mode = 0; m_chain = 0;
  endtask

  task automatic m_key(input int k);
    int d;
    d = k % 16;
    if (k == 16) m_reset();
    else if (m_mode == 5) ;
    else if (k < 16) begin
      case (m_mode)
        0: if (m_a < (1 << (W - 4))) m_a = m_a * 16 + d;
        1: begin m_b = d; m_mode = 2; end
        2: if (m_b < (1 << (W - 4))) m_b = m_b * 16 + d;
        4: begin m_a = d; m_mode = 0; end
        default: ;
      endcase
    end else if (k >= 17 && k <= 20) begin
      if (m_mode == 2) begin m_next = k - 17; m_chain = 1; m_mode = 3; end
      else if (m_mode != 3) begin m_op = k - 17; m_mode = 1; end
    end else if (k == 21 && m_mode == 2) begin
      m_chain = 0; m_mode = 3;
    end
  endtask

  task automatic alu_calc(output int res, output bit err);
    int r;
    case (m_op)
      0: r = m_a + m_b;
      1: r = m_a - m_b;
      2: r = m_a * m_b;
      default: r = (m_b == 0) ? -1 : m_a / m_b;
    endcase
    err = (r < 0) || (r > MAXV);
    res = err ? 0 : r;
    if (force_en) begin res = force_res; err = force_err; end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".disp"}, 32'(o_display), (m_mode == 2) ? m_b : (m_mode == 5) ? 0 : m_a);
    chk({tag, ".err"}, 32'(o_display_error), 32'(m_mode == 5));
    chk({tag, ".rdy"}, 32'(o_key_ready), 32'(m_mode != 3));
    chk({tag, ".busy"}, 32'(o_busy), 32'(m_mode == 3));
    chk({tag, ".avld"}, 32'(o_alu_valid), 32'(m_mode == 3));
  endtask

  // Called at a negedge with the request outstanding; keys are pressed throughout to prove they are held off.
  task automatic do_alu(input int rdly, input int lat);
    int res;
    bit err;
    alu_calc(res, err);
    i_key = 5'($urandom_range(0, 21));
    i_key_valid = 1'b1;
    chk("req.a", 32'(o_alu_a), m_a);
    chk("req.b", 32'(o_alu_b), m_b);
    chk("req.op", 32'(o_alu_op), m_op);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold.avld", 32'(o_alu_valid), 1);
      chk("hold.a", 32'(o_alu_a), m_a);
      chk("hold.b", 32'(o_alu_b), m_b);
      chk("hold.op", 32'(o_alu_op), m_op);
      chk("hold.rdy", 32'(o_key_ready), 0);
      chk("hold.busy", 32'(o_busy), 1);
    end
    i_alu_ready = 1'b1;
    i_alu_result = W'(res);
    i_alu_error = err;
    i_alu_result_valid = (lat == 0);
    @(posedge clk); #1;
    i_alu_ready = 1'b0;
    i_alu_result_valid = 1'b0;
    if (lat > 0) begin
      @(negedge clk);
      chk("wait.avld", 32'(o_alu_valid), 0);
      chk("wait.busy", 32'(o_busy), 1);
      chk("wait.rdy", 32'(o_key_ready), 0);
      for (int i = 1; i < lat; i++) @(negedge clk);
      i_alu_result_valid = 1'b1;
      @(posedge clk); #1;
      i_alu_result_valid = 1'b0;
    end
    i_key_valid = 1'b0;
    if (err) m_mode = 5;
    else begin
      m_a = res; m_b = 0;
      if (m_chain) begin m_op = m_next; m_mode = 1; end
      else m_mode = 4;
    end
    @(negedge clk);
    check_idle("resp");
  endtask

  // Called at a negedge; runs the ALU exchange itself when the key starts one.
  task automatic press(input int k, input int rdly, input int lat);
    chk("key.rdy", 32'(o_key_ready), 1);
    i_key = 5'(k);
    i_key_valid = 1'b1;
    @(posedge clk); #1;
    i_key_valid = 1'b0;
    m_key(k);
    @(negedge clk);
    check_idle("key");
    if (m_mode == 3) do_alu(rdly, lat);
  endtask

  int seq1[5] = '{1, 2, 17, 3, 21};
  int seq3[4] = '{2, 19, 3, 17};
  int seq4[4] = '{5, 20, 0, 21};

  initial begin
    m_reset();
    force_en = 0; force_res = 0; force_err = 0;
    #12;
    chk("rst.disp", 32'(o_display), 0);
    chk("rst.rdy", 32'(o_key_ready), 1);
    chk("rst.avld", 32'(o_alu_valid), 0);
    chk("rst.busy", 32'(o_busy), 0);
    chk("rst.err", 32'(o_display_error), 0);
    chk("rst.a", 32'(o_alu_a), 0);
    chk("rst.b", 32'(o_alu_b), 0);
    chk("rst.op", 32'(o_alu_op), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 12 + 3 = with a canned 0x15 answer, ready held low 3 cycles
    force_en = 1; force_res = 'h15; force_err = 0;
    foreach (seq1[i]) press(seq1[i], 3, 2);
    force_en = 0;
    chk("s1.disp", 32'(o_display), 'h15);

    press(16, 0, 0);
    press(3, 0, 0); press(5, 0, 0); press(7, 0, 0);
    chk("s2.disp", 32'(o_display), 'h35);
    press(16, 0, 0);
    chk("s2.ac", 32'(o_display), 0);

    foreach (seq3[i]) press(seq3[i], 0, 1);
    chk("s3.disp", 32'(o_display), 'h06);
    press(4, 0, 0);
    press(21, 1, 0);
    chk("s3.disp2", 32'(o_display), 'h0a);

    press(16, 0, 0);
    foreach (seq4[i]) press(seq4[i], 0, 2);
    chk("s4.err", 32'(o_display_error), 1);
    press(7, 0, 0);
    chk("s4.disp", 32'(o_display), 0);
    press(16, 0, 0);
    chk("s4.clr", 32'(o_display_error), 0);

    // reset while the ALU is working, then a stale response
    press(1, 0, 0); press(17, 0, 0); press(2, 0, 0);
    i_key = 5'd21; i_key_valid = 1'b1;
    @(posedge clk); #1 i_key_valid = 1'b0;
    @(negedge clk);
    i_alu_ready = 1'b1;
    @(posedge clk); #1 i_alu_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 m_reset();
    chk("mrst.busy", 32'(o_busy), 0);
    chk("mrst.disp", 32'(o_display), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_alu_result = 8'h55; i_alu_result_valid = 1'b1;
    @(posedge clk); #1 i_alu_result_valid = 1'b0;
    @(negedge clk);
    check_idle("late");

    for (int n = 0; n < 600; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 50) k = $urandom_range(0, 15);
      else if (r < 78) k = $urandom_range(17, 20);
      else if (r < 88) k = 21;
      else if (r < 92) k = 16;
      else k = $urandom_range(22, 31);
      press(k, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
